// File: rtl/vram_pkg.sv
// Shared definitions for the video-RAM tile readers: tile geometry and the
// sync_reader state encoding.
package vram_pkg;

  localparam int TILE_ADDR_W = 11;
  localparam int TILE_DATA_W = 64;

  // state    | meaning
  // ST_IDLE  | waiting for start; no reads outstanding
  // ST_READ  | issuing reads, one per cycle while there is buffer room
  // ST_DRAIN | all reads issued; emptying pipeline and buffer to consumer
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } sync_reader_state_t;

endpackage

// File: rtl/sync_reader_fifo.sv
// Small output buffer for sync_reader. Head word is presented directly from
// storage so it stays stable while the consumer stalls; data reads as zero
// whenever the buffer is empty.
module sync_reader_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_wr    = i_push && !o_full;
  assign w_rd    = i_pop && !o_empty;
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage needs no reset: contents are only visible while count is nonzero.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_rd) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sync_reader.sv
// Streams a block of words out of a synchronous-read RAM port onto a
// valid/ready interface, tagging each word with its source address.
// Optional build macro SYNC_READER_CHECKSUM_EN adds a running XOR checksum
// output over the words transferred since the last accepted start.
module sync_reader
  import vram_pkg::*;
#(
  parameter int ADDR_W     = TILE_ADDR_W,
  parameter int DATA_W     = TILE_DATA_W,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addr_from,
  output logic              wren_from,
  input  logic [DATA_W-1:0] rddata_from,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
`ifdef SYNC_READER_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic [ADDR_W-1:0] out_addr
);

  // Buffer holds every word that can be in flight plus the one on the output.
  localparam int DEPTH = RD_LATENCY + 1;
  localparam int OCW   = $clog2(DEPTH + 1);
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  sync_reader_state_t r_state;
  logic [ADDR_W:0]    r_remain;
  logic [ADDR_W:0]    r_left;
  logic [OCW-1:0]     r_outstanding;
  logic               r_pipe_vld  [RD_LATENCY];
  logic [ADDR_W-1:0]  r_pipe_addr [RD_LATENCY];

  logic                     w_issue;
  logic                     w_pop;
  logic                     w_fifo_full;
  logic                     w_fifo_empty;
  logic [DATA_W+ADDR_W-1:0] w_fifo_dout;

  assign wren_from = 1'b0;
  assign out_valid = !w_fifo_empty;
  assign out_data  = w_fifo_dout[DATA_W-1:0];
  assign out_addr  = w_fifo_dout[DATA_W +: ADDR_W];
  assign w_pop     = out_valid && out_ready;

  // A word leaving this cycle frees a slot, so a read may issue against it;
  // this keeps one word per cycle flowing with out_ready held high.
  assign w_issue = (r_state == ST_READ)
                && ((r_outstanding < OCW'(DEPTH)) || w_pop)
                && (!w_fifo_full || w_pop);

  // Sequencing FSM with registered busy/done and read address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      addr_from <= '0;
      r_remain  <= '0;
      r_left    <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (count != '0) begin
              r_state   <= ST_READ;
              busy      <= 1'b1;
              addr_from <= base_addr;
              r_remain  <= count;
              r_left    <= count;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (w_issue) begin
            addr_from <= addr_from + ADDR_W'(1);
            r_remain  <= r_remain - CNT_ONE;
            if (r_remain == CNT_ONE) r_state <= ST_DRAIN;
          end
        end
        default: ;
      endcase
      if ((r_state != ST_IDLE) && w_pop) begin
        r_left <= r_left - CNT_ONE;
        if (r_left == CNT_ONE) begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  // Reads in flight plus words buffered; bounds issue so the buffer never overflows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
    end else begin
      case ({w_issue, w_pop})
        2'b10:   r_outstanding <= r_outstanding + OCW'(1);
        2'b01:   r_outstanding <= r_outstanding - OCW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Track each issued address until the RAM returns its word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_pipe_vld[i]  <= 1'b0;
        r_pipe_addr[i] <= '0;
      end
    end else begin
      r_pipe_vld[0]  <= w_issue;
      r_pipe_addr[0] <= addr_from;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_addr[i] <= r_pipe_addr[i-1];
      end
    end
  end

  sync_reader_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W + ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_pipe_vld[RD_LATENCY-1]),
    .i_data  ({r_pipe_addr[RD_LATENCY-1], rddata_from}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

`ifdef SYNC_READER_CHECKSUM_EN
  // Running XOR of transferred words, restarted by every accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (start && (r_state == ST_IDLE)) begin
      checksum <= '0;
    end else if (w_pop) begin
      checksum <= checksum ^ out_data;
    end
  end
`endif

endmodule

// File: tb/tb_sync_reader.sv
// Bench for sync_reader: RAM model returns word i at address i, expected
// words are queued when a start is driven and popped on each transfer.
module tb_sync_reader;

  localparam int AW  = 11;
  localparam int DW  = 64;
  localparam int LAT = 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   count;
  logic          busy;
  logic          done;
  logic [AW-1:0] addr_from;
  logic          wren_from;
  logic [DW-1:0] rddata_from;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
`ifdef SYNC_READER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  logic [DW-1:0] ram_q [LAT];

  sync_reader #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .RD_LATENCY (LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .addr_from   (addr_from),
    .wren_from   (wren_from),
    .rddata_from (rddata_from),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
`ifdef SYNC_READER_CHECKSUM_EN
    .checksum    (checksum),
`endif
    .out_addr    (out_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM, word i holds value i, LAT cycles of read latency.
  always @(posedge clk) begin
    ram_q[0] <= DW'(addr_from);
    for (int i = 1; i < LAT; i++) ram_q[i] <= ram_q[i-1];
  end
  assign rddata_from = ram_q[LAT-1];

  // Drive a one-cycle start from a negedge; queue the words it should produce.
  task automatic start_xfer(input int b, input int c, input bit accepted);
    start     = 1'b1;
    base_addr = AW'(b);
    count     = (AW+1)'(c);
    if (accepted) begin
      for (int i = 0; i < c; i++) begin
        exp_t e;
        e.addr = AW'((b + i) % (1 << AW));
        e.data = DW'(e.addr);
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    count = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, out_valid} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags: busy/done/valid=%b required 000", {busy, done, out_valid});
    end
    n_cmp++;
    if (addr_from !== '0 || out_addr !== '0) begin
      n_bad++;
      $display("FAIL reset_addr: addr_from=%0d out_addr=%0d required 0/0", addr_from, out_addr);
    end
    n_cmp++;
    if (out_data !== '0 || wren_from !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_data: out_data=%0h wren=%b required 0/0", out_data, wren_from);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_stream();
    int first_v, done_n, got;
    exp_t e;
    first_v = -1; done_n = -1; got = 0;
    out_ready = 1'b1;
    start_xfer(0, 2048, 1'b1);
    for (int n = 0; n < 2200 && done_n < 0; n++) begin
      if (n > 0) @(negedge clk);
      if (out_valid && first_v < 0) first_v = n;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL full_extra: addr %0d arrived, none expected", out_addr);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data || out_addr !== e.addr) begin
            n_bad++;
            $display("FAIL full_word: got addr %0d data %0h required addr %0d data %0h",
                     out_addr, out_data, e.addr, e.data);
          end
        end
        got++;
      end
      if (done) done_n = n;
    end
    n_cmp++;
    if (first_v != LAT + 1) begin
      n_bad++;
      $display("FAIL full_first_valid: cycle %0d required %0d", first_v, LAT + 1);
    end
    n_cmp++;
    if (done_n != 2048 + LAT + 1) begin
      n_bad++;
      $display("FAIL full_done_cycle: cycle %0d required %0d", done_n, 2048 + LAT + 1);
    end
    n_cmp++;
    if (got != 2048 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL full_count: got %0d left %0d required 2048/0", got, exp_q.size());
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL full_busy_at_done: busy=%b required 0", busy);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL full_done_width: done=%b required 0", done);
    end
    exp_q.delete();
  endtask

  task automatic test_wrap();
    int done_n, got;
    exp_t e;
    done_n = -1; got = 0;
    out_ready = 1'b1;
    start_xfer(2046, 4, 1'b1);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_busy: busy=%b required 1", busy);
    end
    for (int n = 0; n < 50 && done_n < 0; n++) begin
      if (n > 0) @(negedge clk);
      if (out_valid && out_ready) begin
        n_cmp++;
        e = exp_q.pop_front();
        if (out_data !== e.data || out_addr !== e.addr) begin
          n_bad++;
          $display("FAIL wrap_word: got addr %0d data %0h required addr %0d data %0h",
                   out_addr, out_data, e.addr, e.data);
        end
        got++;
      end
      if (done) done_n = n;
    end
    n_cmp++;
    if (done_n < 0 || got != 4) begin
      n_bad++;
      $display("FAIL wrap_done: done_cycle %0d words %0d required done and 4", done_n, got);
    end
    @(negedge clk);
    exp_q.delete();
  endtask

  task automatic test_stall();
    int done_n, got;
    logic p_valid, p_ready;
    logic [DW-1:0] p_data;
    logic [AW-1:0] p_addr;
    exp_t e;
    done_n = -1; got = 0; p_valid = 1'b0; p_ready = 1'b0;
    p_data = '0; p_addr = '0;
    out_ready = 1'b0;
    start_xfer(0, 16, 1'b1);
    for (int n = 0; n < 200 && done_n < 0; n++) begin
      if (n > 0) @(negedge clk);
      start = 1'b0;
      // A start while busy must not change the stream.
      if (n == 4) begin
        start = 1'b1;
        base_addr = AW'(500);
        count = (AW+1)'(7);
      end
      out_ready = (n % 3 == 0);
      if (p_valid && !p_ready) begin
        n_cmp++;
        if (!out_valid || out_data !== p_data || out_addr !== p_addr) begin
          n_bad++;
          $display("FAIL stall_hold: valid %b addr %0d data %0h required 1 addr %0d data %0h",
                   out_valid, out_addr, out_data, p_addr, p_data);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL stall_extra: addr %0d arrived, none expected", out_addr);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data || out_addr !== e.addr) begin
            n_bad++;
            $display("FAIL stall_word: got addr %0d data %0h required addr %0d data %0h",
                     out_addr, out_data, e.addr, e.data);
          end
        end
        got++;
      end
      p_valid = out_valid; p_ready = out_ready; p_data = out_data; p_addr = out_addr;
      if (done) done_n = n;
    end
    start = 1'b0;
    n_cmp++;
    if (done_n < 0 || got != 16 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL stall_total: done_cycle %0d words %0d required done and 16", done_n, got);
    end
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_ignored_start: valid %b busy %b required 0/0", out_valid, busy);
      end
    end
    out_ready = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_zero_count();
    int done_n, n_done, seen_v, seen_b;
    done_n = -1; n_done = 0; seen_v = 0; seen_b = 0;
    out_ready = 1'b1;
    start_xfer(100, 0, 1'b1);
    for (int n = 0; n < 8; n++) begin
      if (n > 0) @(negedge clk);
      if (done) begin
        n_done++;
        if (done_n < 0) done_n = n;
      end
      if (out_valid) seen_v++;
      if (busy) seen_b++;
    end
    n_cmp++;
    if (done_n != 0 || n_done != 1) begin
      n_bad++;
      $display("FAIL zero_done: first cycle %0d pulses %0d required 0/1", done_n, n_done);
    end
    n_cmp++;
    if (seen_v != 0 || seen_b != 0) begin
      n_bad++;
      $display("FAIL zero_quiet: valid cycles %0d busy cycles %0d required 0/0", seen_v, seen_b);
    end
  endtask

  task automatic test_reset_abort();
    int got, done_n, seen;
    exp_t e;
    got = 0; done_n = -1; seen = 0;
    out_ready = 1'b1;
    start_xfer(0, 64, 1'b1);
    for (int n = 0; n < 40 && got < 5; n++) begin
      if (n > 0) @(negedge clk);
      if (out_valid && out_ready) begin
        n_cmp++;
        e = exp_q.pop_front();
        if (out_data !== e.data || out_addr !== e.addr) begin
          n_bad++;
          $display("FAIL abort_pre_word: got addr %0d required %0d", out_addr, e.addr);
        end
        got++;
      end
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, out_valid} !== 3'b000 || addr_from !== '0 ||
        out_addr !== '0 || out_data !== '0) begin
      n_bad++;
      $display("FAIL abort_async: busy %b done %b valid %b addr_from %0d out_addr %0d data %0h required all 0",
               busy, done, out_valid, addr_from, out_addr, out_data);
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (done || out_valid || busy) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL abort_stale: %0d cycles with activity after release required 0", seen);
    end
    got = 0;
    start_xfer(10, 3, 1'b1);
    for (int n = 0; n < 40 && done_n < 0; n++) begin
      if (n > 0) @(negedge clk);
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL abort_post_extra: addr %0d arrived, none expected", out_addr);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data || out_addr !== e.addr) begin
            n_bad++;
            $display("FAIL abort_post_word: got addr %0d data %0h required addr %0d data %0h",
                     out_addr, out_data, e.addr, e.data);
          end
        end
        got++;
      end
      if (done) done_n = n;
    end
    n_cmp++;
    if (done_n < 0 || got != 3) begin
      n_bad++;
      $display("FAIL abort_post_done: done_cycle %0d words %0d required done and 3", done_n, got);
    end
    @(negedge clk);
    exp_q.delete();
  endtask

`ifdef SYNC_READER_CHECKSUM_EN
  task automatic test_checksum();
    int done_n;
    logic [DW-1:0] want;
    int b_tab[2] = '{0, 5};
    int c_tab[2] = '{4, 3};
    out_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      want = '0;
      for (int i = 0; i < c_tab[t]; i++) want = want ^ DW'(b_tab[t] + i);
      done_n = -1;
      start_xfer(b_tab[t], c_tab[t], 1'b0);
      for (int n = 0; n < 40 && done_n < 0; n++) begin
        if (n > 0) @(negedge clk);
        if (done) done_n = n;
      end
      n_cmp++;
      if (done_n < 0 || checksum !== want) begin
        n_bad++;
        $display("FAIL checksum_%0d: got %0h required %0h (done_cycle %0d)", t, checksum, want, done_n);
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_stream();
    test_wrap();
    test_stall();
    test_zero_count();
    test_reset_abort();
`ifdef SYNC_READER_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_reader.md
SYNC_READER -- requirements
Module: sync_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, the RAM word-address width (2048 words).
REQ-002 SHALL have parameter DATA_W, default 64, the RAM word width.
REQ-003 SHALL have parameter RD_LATENCY, default 1, in 1..4: cycles from addr_from sampled to rddata_from valid.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle request to begin a streamed read.
REQ-007 base_addr  input  ADDR_W  first word address, sampled on accepted start.
REQ-008 count  input  ADDR_W+1  words to read, sampled on accepted start; 0 is legal.
REQ-009 busy  output  1  transfer in progress.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 addr_from  output  ADDR_W  read address to the source RAM port.
REQ-012 wren_from  output  1  source RAM write enable; constant 0.
REQ-013 rddata_from  input  DATA_W  source RAM read data.
REQ-014 out_valid  output  1  stream word available.
REQ-015 out_ready  input  1  consumer accepts the word.
REQ-016 out_data  output  DATA_W  stream word.
REQ-017 out_addr  output  ADDR_W  RAM address the out_data word came from.

Function
REQ-018 States: IDLE, READ, DRAIN. IDLE->READ on start with count!=0. READ->DRAIN when the last read issues. DRAIN->IDLE on the last accepted transfer.
REQ-019 Start in IDLE with count==0: no reads; done pulses the next cycle; busy stays 0.
REQ-020 Start while busy SHALL be ignored; it does not alter base_addr or count.
REQ-021 busy SHALL be 1 from the cycle after an accepted start (count!=0) through the cycle of the last transfer.
REQ-022 Reads issue only in READ, one per cycle, and only while (in-flight reads + buffered words) < RD_LATENCY+1.
REQ-023 addr_from SHALL step by 1 per issued read and wrap modulo 2^ADDR_W (e.g. base 2047, count 2 reads 2047 then 0).
REQ-024 Each rddata_from word SHALL be captured exactly RD_LATENCY cycles after its read issues; no word is dropped or duplicated under any out_ready pattern.
REQ-025 A transfer occurs when out_valid and out_ready are both 1; words leave in address-issue order.
REQ-026 While out_valid is 1 and out_ready is 0, out_data and out_addr SHALL hold stable.
REQ-027 With out_ready held at 1, sustained throughput SHALL be one word per cycle; first out_valid comes RD_LATENCY+1 cycles after start.
REQ-028 done SHALL pulse in the cycle after the last transfer; busy is 0 in that cycle.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE and clear the buffer, the in-flight tracking and the checksum; outputs are busy=0, done=0, out_valid=0, addr_from=0, out_data=0, out_addr=0.
REQ-030 A reset during READ or DRAIN SHALL abort the transfer silently: no done, and no stale word after reset release.

Configuration
REQ-031 With macro SYNC_READER_CHECKSUM_EN defined: extra output checksum (DATA_W) is the XOR of all words transferred since the last accepted start; it is cleared on an accepted start and is final in the done cycle.
REQ-032 Without SYNC_READER_CHECKSUM_EN: no checksum port and no checksum logic.

Structure
REQ-033 Shared package vram_pkg SHALL hold TILE_ADDR_W=11, TILE_DATA_W=64 and the state enum typedef sync_reader_state_t.
REQ-034 The output buffer SHALL be one sub-module, sync_reader_fifo: depth RD_LATENCY+1, width DATA_W+ADDR_W, with full/empty flags.

Verification
REQ-035 Source RAM word i = i; base 0, count 2048, out_ready=1 -> 2048 words, data 0..2047 in order, done at cycle 2048+RD_LATENCY+1 after start.
REQ-036 Base 2046, count 4 -> out_addr 2046, 2047, 0, 1 with matching data; then done.
REQ-037 Base 0, count 16, out_ready toggling 1 cycle on/2 off -> 16 words in order, none lost; out_data stable during stalls.
REQ-038 Count 0 -> done pulse 1 cycle after start; out_valid never 1; busy never 1.
REQ-039 rst_n pulled low after the 5th transfer of a count-64 stream -> outputs reset at once; no done; after release, a new start (base 10, count 3) streams words 10..12 correctly.
REQ-040 With SYNC_READER_CHECKSUM_EN, data pattern i, count 4 from base 0 -> checksum 0x0 (0^1^2^3) at done.
